ram_port_arbiter: RTL and testbench

- Shares one simple dual-port synchronous RAM (one write port, one read port, 1-cycle registered read) between two requesters, m0 and m1.
- The read and write channels are arbitrated independently, each with a 2-way round-robin.
- Read data returns with a per-master valid strobe, aligned to the RAM's one-cycle read latency.
- Sits between the matrix compute/load engines and the data RAM.

---
 rtl/ram_port_arbiter.sv | 116 +++++++++++
 tb/tb_ram_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter for a simple dual-port RAM: independent round-robin on the
// read and write channels, with per-master read-valid strobes aligned to the RAM latency.
module ram_port_arbiter #(
  parameter int unsigned ADDR_LEN = 16,
  parameter int unsigned DATA_LEN = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                m0_rd_req,
  input  logic [ADDR_LEN-1:0] m0_rd_addr,
  output logic                m0_rd_gnt,
  output logic                m0_rd_valid,
  output logic [DATA_LEN-1:0] m0_rd_data,
  input  logic                m1_rd_req,
  input  logic [ADDR_LEN-1:0] m1_rd_addr,
  output logic                m1_rd_gnt,
  output logic                m1_rd_valid,
  output logic [DATA_LEN-1:0] m1_rd_data,
  input  logic                m0_wr_req,
  input  logic [ADDR_LEN-1:0] m0_wr_addr,
  input  logic [DATA_LEN-1:0] m0_wr_data,
  output logic                m0_wr_gnt,
  input  logic                m1_wr_req,
  input  logic [ADDR_LEN-1:0] m1_wr_addr,
  input  logic [DATA_LEN-1:0] m1_wr_data,
  output logic                m1_wr_gnt,
  output logic                ram_wr_en,
  output logic [ADDR_LEN-1:0] ram_wr_addr,
  output logic [DATA_LEN-1:0] ram_wr_data,
  output logic [ADDR_LEN-1:0] ram_rd_addr,
  input  logic [DATA_LEN-1:0] ram_Q
);

  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_pend_id_q, rd_pend_id_d;
  logic [ADDR_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_LEN-1:0] wr_data_q, wr_data_d;

  // Round-robin grants; the pointer names the master preferred on contention.
  always_comb begin
    m0_rd_gnt = 1'b0;
    m1_rd_gnt = 1'b0;
    m0_wr_gnt = 1'b0;
    m1_wr_gnt = 1'b0;
    if (!RST) begin
      m0_rd_gnt = m0_rd_req && (!m1_rd_req || !rd_ptr_q);
      m1_rd_gnt = m1_rd_req && (!m0_rd_req ||  rd_ptr_q);
      m0_wr_gnt = m0_wr_req && (!m1_wr_req || !wr_ptr_q);
      m1_wr_gnt = m1_wr_req && (!m0_wr_req ||  wr_ptr_q);
    end
  end

  // Next-state: pointers, pending read tag and held RAM-side address/data.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_pend_d    = m0_rd_gnt | m1_rd_gnt;
    rd_pend_id_d = rd_pend_id_q;
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (m0_rd_gnt) begin
      rd_ptr_d     = 1'b1;
      rd_pend_id_d = 1'b0;
      rd_addr_d    = m0_rd_addr;
    end else if (m1_rd_gnt) begin
      rd_ptr_d     = 1'b0;
      rd_pend_id_d = 1'b1;
      rd_addr_d    = m1_rd_addr;
    end
    if (m0_wr_gnt) begin
      wr_ptr_d  = 1'b1;
      wr_addr_d = m0_wr_addr;
      wr_data_d = m0_wr_data;
    end else if (m1_wr_gnt) begin
      wr_ptr_d  = 1'b0;
      wr_addr_d = m1_wr_addr;
      wr_data_d = m1_wr_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_pend_id_q <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_pend_q    <= rd_pend_d;
      rd_pend_id_q <= rd_pend_id_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // RAM-side muxes pass the granted request through and hold the last one when idle.
  assign ram_rd_addr = rd_addr_d;
  assign ram_wr_en   = m0_wr_gnt | m1_wr_gnt;
  assign ram_wr_addr = wr_addr_d;
  assign ram_wr_data = wr_data_d;

  assign m0_rd_valid = rd_pend_q & ~rd_pend_id_q;
  assign m1_rd_valid = rd_pend_q &  rd_pend_id_q;
  assign m0_rd_data  = ram_Q;
  assign m1_rd_data  = ram_Q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-before-write RAM.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          m0_rd_req = 1'b0, m1_rd_req = 1'b0;
  logic [AW-1:0] m0_rd_addr = '0, m1_rd_addr = '0;
  logic          m0_rd_gnt, m1_rd_gnt, m0_rd_valid, m1_rd_valid;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          m0_wr_req = 1'b0, m1_wr_req = 1'b0;
  logic [AW-1:0] m0_wr_addr = '0, m1_wr_addr = '0;
  logic [DW-1:0] m0_wr_data = '0, m1_wr_data = '0;
  logic          m0_wr_gnt, m1_wr_gnt;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_Q = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_Q <= mem[ram_rd_addr];
  end

  ram_port_arbiter #(.ADDR_LEN(AW), .DATA_LEN(DW)) dut (
    .CLK(CLK), .RST(RST),
    .m0_rd_req(m0_rd_req), .m0_rd_addr(m0_rd_addr), .m0_rd_gnt(m0_rd_gnt),
    .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
    .m1_rd_req(m1_rd_req), .m1_rd_addr(m1_rd_addr), .m1_rd_gnt(m1_rd_gnt),
    .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
    .m0_wr_req(m0_wr_req), .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data),
    .m0_wr_gnt(m0_wr_gnt),
    .m1_wr_req(m1_wr_req), .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data),
    .m1_wr_gnt(m1_wr_gnt),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_Q(ram_Q)
  );

  task automatic clear_reqs();
    m0_rd_req = 1'b0; m1_rd_req = 1'b0;
    m0_wr_req = 1'b0; m1_wr_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    clear_reqs();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    m0_rd_req = 1'b1; m1_rd_req = 1'b1; m0_wr_req = 1'b1; m1_wr_req = 1'b1;
    #1;
    n_checks++;
    if ({m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt, ram_wr_en} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_gnts: got %b expected 00000",
               {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt, ram_wr_en});
    end
    @(negedge CLK);
    n_checks++;
    if ({m0_rd_valid, m1_rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 00", {m0_rd_valid, m1_rd_valid});
    end
    clear_reqs();
    RST = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    m0_rd_req = 1'b1; m0_rd_addr = 16'h0010;
    #1;
    n_checks++;
    if ({m0_rd_gnt, m1_rd_gnt} !== 2'b10 || ram_rd_addr !== 16'h0010) begin
      n_fail++;
      $display("FAIL single_gnt: gnt=%b addr=%h expected gnt=10 addr=0010",
               {m0_rd_gnt, m1_rd_gnt}, ram_rd_addr);
    end
    @(negedge CLK);
    m0_rd_req = 1'b0;
    n_checks++;
    if (m0_rd_valid !== 1'b1 || m1_rd_valid !== 1'b0 || m0_rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL single_data: v0=%b v1=%b data=%h expected v0=1 v1=0 data=5a",
               m0_rd_valid, m1_rd_valid, m0_rd_data);
    end
  endtask

  task automatic test_round_robin();
    logic exp0;
    apply_reset();
    m0_rd_addr = 16'h0010; m1_rd_addr = 16'h0020;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        exp0 = (i % 2) == 1;
        n_checks++;
        if (m0_rd_valid !== exp0 || m1_rd_valid !== !exp0 ||
            m0_rd_data !== (exp0 ? 8'h5A : 8'h77)) begin
          n_fail++;
          $display("FAIL rr_valid[%0d]: v0=%b v1=%b data=%h expected v0=%b v1=%b data=%h",
                   i, m0_rd_valid, m1_rd_valid, m0_rd_data, exp0, !exp0,
                   exp0 ? 8'h5A : 8'h77);
        end
      end
      if (i < 4) begin
        m0_rd_req = 1'b1; m1_rd_req = 1'b1;
        #1;
        exp0 = (i % 2) == 0;
        n_checks++;
        if (m0_rd_gnt !== exp0 || m1_rd_gnt !== !exp0) begin
          n_fail++;
          $display("FAIL rr_gnt[%0d]: gnt=%b%b expected %b%b",
                   i, m0_rd_gnt, m1_rd_gnt, exp0, !exp0);
        end
      end else begin
        clear_reqs();
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_read_during_write();
    apply_reset();
    m1_wr_req = 1'b1; m1_wr_addr = 16'h0003; m1_wr_data = 8'hA5;
    m0_rd_req = 1'b1; m0_rd_addr = 16'h0003;
    #1;
    n_checks++;
    if (m0_rd_gnt !== 1'b1 || m1_wr_gnt !== 1'b1 || ram_wr_en !== 1'b1 ||
        ram_wr_addr !== 16'h0003 || ram_wr_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdw_gnt: rg=%b wg=%b en=%b wa=%h wd=%h expected 1 1 1 0003 a5",
               m0_rd_gnt, m1_wr_gnt, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    @(negedge CLK);
    m1_wr_req = 1'b0;
    n_checks++;
    if (m0_rd_valid !== 1'b1 || m0_rd_data !== 8'h11) begin
      n_fail++;
      $display("FAIL rdw_old: v=%b data=%h expected v=1 data=11", m0_rd_valid, m0_rd_data);
    end
    #1;
    n_checks++;
    if (m0_rd_gnt !== 1'b1 || ram_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rdw_regnt: gnt=%b en=%b expected gnt=1 en=0", m0_rd_gnt, ram_wr_en);
    end
    @(negedge CLK);
    m0_rd_req = 1'b0;
    n_checks++;
    if (m0_rd_valid !== 1'b1 || m0_rd_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL rdw_new: v=%b data=%h expected v=1 data=a5", m0_rd_valid, m0_rd_data);
    end
  endtask

  task automatic test_dual_write();
    apply_reset();
    m0_wr_req = 1'b1; m0_wr_addr = 16'h0001; m0_wr_data = 8'h22;
    m1_wr_req = 1'b1; m1_wr_addr = 16'h0002; m1_wr_data = 8'h33;
    #1;
    n_checks++;
    if ({m0_wr_gnt, m1_wr_gnt} !== 2'b10 || ram_wr_en !== 1'b1 ||
        ram_wr_addr !== 16'h0001 || ram_wr_data !== 8'h22) begin
      n_fail++;
      $display("FAIL wr_first: gnt=%b en=%b a=%h d=%h expected 10 1 0001 22",
               {m0_wr_gnt, m1_wr_gnt}, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    @(negedge CLK);
    m0_wr_req = 1'b0;
    #1;
    n_checks++;
    if ({m0_wr_gnt, m1_wr_gnt} !== 2'b01 || ram_wr_en !== 1'b1 ||
        ram_wr_addr !== 16'h0002 || ram_wr_data !== 8'h33) begin
      n_fail++;
      $display("FAIL wr_second: gnt=%b en=%b a=%h d=%h expected 01 1 0002 33",
               {m0_wr_gnt, m1_wr_gnt}, ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    @(negedge CLK);
    m1_wr_req = 1'b0;
    m0_rd_req = 1'b1; m0_rd_addr = 16'h0001;
    #1;
    n_checks++;
    if (ram_wr_en !== 1'b0 || ram_wr_addr !== 16'h0002 || ram_wr_data !== 8'h33) begin
      n_fail++;
      $display("FAIL wr_idle_hold: en=%b a=%h d=%h expected 0 0002 33",
               ram_wr_en, ram_wr_addr, ram_wr_data);
    end
    @(negedge CLK);
    n_checks++;
    if (m0_rd_valid !== 1'b1 || m0_rd_data !== 8'h22) begin
      n_fail++;
      $display("FAIL wr_readback1: v=%b data=%h expected v=1 data=22", m0_rd_valid, m0_rd_data);
    end
    m0_rd_addr = 16'h0002;
    @(negedge CLK);
    m0_rd_req = 1'b0;
    n_checks++;
    if (m0_rd_valid !== 1'b1 || m0_rd_data !== 8'h33) begin
      n_fail++;
      $display("FAIL wr_readback2: v=%b data=%h expected v=1 data=33", m0_rd_valid, m0_rd_data);
    end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    m0_rd_req = 1'b1; m0_rd_addr = 16'h0010;
    @(negedge CLK);
    n_checks++;
    if (m0_rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_first_valid: got %b expected 1", m0_rd_valid);
    end
    #1;
    n_checks++;
    if (m0_rd_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_second_gnt: got %b expected 1", m0_rd_gnt);
    end
    #1;
    RST = 1'b1;
    m0_rd_req = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({m0_rd_valid, m1_rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_discard: valids=%b expected 00", {m0_rd_valid, m1_rd_valid});
    end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({m0_rd_valid, m1_rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_after: valids=%b expected 00", {m0_rd_valid, m1_rd_valid});
    end
    m0_rd_req = 1'b1; m1_rd_req = 1'b1; m1_rd_addr = 16'h0020;
    m0_wr_req = 1'b1; m1_wr_req = 1'b1;
    #1;
    n_checks++;
    if ({m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt} !== 4'b1010) begin
      n_fail++;
      $display("FAIL midrst_ptr: gnts=%b expected 1010",
               {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt});
    end
    m0_wr_addr = 16'h0100; m0_wr_data = 8'hEE;
    @(negedge CLK);
    clear_reqs();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #1;
      n_checks++;
      if ({m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt, ram_wr_en,
           m0_rd_valid, m1_rd_valid} !== 7'b0) begin
        n_fail++;
        $display("FAIL idle[%0d]: gnts/en/valids=%b expected 0000000", i,
                 {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt, ram_wr_en,
                  m0_rd_valid, m1_rd_valid});
      end
    end
    m0_rd_req = 1'b1; m1_rd_req = 1'b1; m0_wr_req = 1'b1; m1_wr_req = 1'b1;
    #1;
    n_checks++;
    if ({m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt} !== 4'b0101) begin
      n_fail++;
      $display("FAIL idle_ptr_hold: gnts=%b expected 0101",
               {m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt});
    end
    @(negedge CLK);
    clear_reqs();
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
    mem[16'h0003] = 8'h11;
    mem[16'h0010] = 8'h5A;
    mem[16'h0020] = 8'h77;
    test_reset();
    test_single_read();
    test_round_robin();
    test_read_during_write();
    test_dual_write();
    test_reset_mid_read();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
